// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word handshake between a byte source and the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;

  // Source side: offers words, observes holding-register space
  modport master (
    output tx_valid,
    output tx_byte,
    input  tx_ready
  );

  // Transmitter side: accepts words when its holding register is empty
  modport slave (
    input  tx_valid,
    input  tx_byte,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (DATA_BITS data, STOP_BITS stop, LSB first)
// with a one-entry holding register so consecutive frames leave with no idle gap.
// Optional parity bit after the data bits: define UART_TX_PARITY_EN (sense set by PARITY_ODD).
// CLKS_PER_BIT = CLK_HZ / BAUD must be at least 2.
module uart_tx_param #(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_param_if.slave bus,
  output logic          tx_data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t state;
  state_t state_nxt;

  // Datapath state
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 stop_idx;
  logic                 stop_idx_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] hold_nxt;
  logic                 ready_nxt;

`ifdef UART_TX_PARITY_EN
  logic parity;
  logic parity_nxt;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Output next-values
  logic tx_data_nxt;
  logic busy_nxt;
  logic done_nxt;

  // Decoded events
  logic hold_full;
  logic accept;
  logic bit_end;
  logic data_last;
  logic stop_last;
  logic frame_end;
  logic load;

  assign hold_full = !bus.tx_ready;
  assign accept    = bus.tx_valid && bus.tx_ready;
  assign bit_end   = (bit_cnt == CNT_LAST);
  assign data_last = (state == S_DATA) && bit_end && (idx == IDX_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign frame_end = (state == S_STOP) && bit_end && stop_last;
  // The held word moves to the shifter when idle, or straight after the last stop bit
  assign load      = hold_full && ((state == S_IDLE) || frame_end);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hold_full) state_nxt = S_START;
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
`ifdef UART_TX_PARITY_EN
        if (data_last) state_nxt = S_PARITY;
`else
        if (data_last) state_nxt = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (frame_end) state_nxt = hold_full ? S_START : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath next-values: bit timer, data index, stop index, shifter and holding register
  always_comb begin
    bit_cnt_nxt  = bit_cnt;
    idx_nxt      = idx;
    stop_idx_nxt = stop_idx;
    shift_nxt    = shift;
    hold_nxt     = hold;
    ready_nxt    = bus.tx_ready;
`ifdef UART_TX_PARITY_EN
    parity_nxt   = parity;
`endif

    if (state == S_IDLE) begin
      bit_cnt_nxt = '0;
    end else if (bit_end) begin
      bit_cnt_nxt = '0;
    end else begin
      bit_cnt_nxt = bit_cnt + CNT_W'(1);
    end

    if ((state == S_DATA) && bit_end) begin
      if (idx == IDX_LAST) begin
        idx_nxt = '0;
      end else begin
        idx_nxt   = idx + IDX_W'(1);
        shift_nxt = shift >> 1;
      end
    end

    if ((state == S_STOP) && bit_end) begin
      stop_idx_nxt = stop_last ? 1'b0 : 1'b1;
    end

    if (load) begin
      shift_nxt  = hold;
      ready_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_nxt = (^hold) ^ PARITY_ODD;
`endif
    end

    // Only possible while the holding register is empty, so never collides with load
    if (accept) begin
      hold_nxt  = bus.tx_byte;
      ready_nxt = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      hold     <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      bit_cnt  <= bit_cnt_nxt;
      idx      <= idx_nxt;
      stop_idx <= stop_idx_nxt;
      shift    <= shift_nxt;
      hold     <= hold_nxt;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_nxt;
`endif
    end
  end

  // Output decode from the upcoming state so the line changes on the same edge as the state
  always_comb begin
    tx_data_nxt = 1'b1;
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = frame_end;
    case (state_nxt)
      S_START:  tx_data_nxt = 1'b0;
      S_DATA:   tx_data_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_data_nxt = parity_nxt;
`endif
      default:  tx_data_nxt = 1'b1;
    endcase
  end

  // Output registers; reset drives the line idle immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.tx_ready <= 1'b1;
    end else begin
      tx_data      <= tx_data_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      bus.tx_ready <= ready_nxt;
    end
  end

endmodule
